// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared load/store encodings, FSM states and bus width for the memory stage
package mem_stage_pkg;
    localparam int REG_BUS = 64;
    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LD  = 3'b011;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;
    localparam logic [2:0] LSU_LWU = 3'b110;
    typedef enum logic [1:0] {MEM_IDLE, MEM_REQ, MEM_WAIT, MEM_OUT} state_t;
endpackage

// File: rtl/mem_stage_align.sv
// mem_align: byte-lane store mask/data, load shift and extension, and misalignment detection
module mem_align import mem_stage_pkg::*; #(
    parameter int XLEN = REG_BUS
) (
    input  logic [2:0]      off,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] st_data,
    input  logic [XLEN-1:0] rdata,
    output logic [7:0]      wmask,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ldata,
    output logic            misalign
);
    logic [1:0]      sz;
    logic [XLEN-1:0] sh;
    assign sz = funct3[1:0];
    always_comb begin
        sh       = rdata >> {off, 3'b000};
        wmask    = (sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : sz == 2'd2 ? 8'h0F : 8'hFF) << off;
        wdata    = st_data << {off, 3'b000};
        misalign = sz == 2'd1 ? off[0] : sz == 2'd2 ? |off[1:0] : sz == 2'd3 ? |off : 1'b0;
        ldata    = funct3 == LSU_LB  ? {{(XLEN-8){sh[7]}}, sh[7:0]} :
                   funct3 == LSU_LH  ? {{(XLEN-16){sh[15]}}, sh[15:0]} :
                   funct3 == LSU_LW  ? {{(XLEN-32){sh[31]}}, sh[31:0]} :
                   funct3 == LSU_LBU ? {{(XLEN-8){1'b0}}, sh[7:0]} :
                   funct3 == LSU_LHU ? {{(XLEN-16){1'b0}}, sh[15:0]} :
                   funct3 == LSU_LWU ? {{(XLEN-32){1'b0}}, sh[31:0]} : sh;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store stage between exe_stage and register write-back
// Non-memory bundles bypass the FSM; memory bundles walk IDLE->REQ->WAIT->OUT.
module mem_stage import mem_stage_pkg::*; #(
    parameter int XLEN   = REG_BUS,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_alu_res,
    input  logic [XLEN-1:0]   in_st_data,
    input  logic [4:0]        in_rd_addr,
    input  logic              in_rd_wen,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [7:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [4:0]        wb_rd_addr,
    output logic              wb_rd_wen,
    output logic [XLEN-1:0]   wb_rd_data,
    output logic              wb_misalign
);
    state_t          state, state_nx;
    logic [XLEN-1:0] addr_q, st_q, wdata, ldata;
    logic [2:0]      f3_q, off, f3;
    logic [4:0]      rd_q;
    logic            wen_q, store_q, xfer, is_mem, mis, req;
    logic [7:0]      wmask;
    assign in_ready = state == MEM_IDLE && (!wb_valid || wb_ready);
    assign xfer     = in_valid && in_ready;
    assign is_mem   = in_is_load || in_is_store;
    assign req      = state == MEM_REQ;
    // While idle the aligner checks the incoming address; afterwards it serves the captured bundle.
    assign off = state == MEM_IDLE ? in_alu_res[2:0] : addr_q[2:0];
    assign f3  = state == MEM_IDLE ? in_funct3 : f3_q;
    mem_align #(.XLEN(XLEN)) u_align (
        .off      (off),
        .funct3   (f3),
        .st_data  (st_q),
        .rdata    (mem_resp_rdata),
        .wmask    (wmask),
        .wdata    (wdata),
        .ldata    (ldata),
        .misalign (mis)
    );
    assign mem_req_valid = req;
    assign mem_req_addr  = req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
    assign mem_req_wen   = req && store_q;
    assign mem_req_wdata = req ? wdata : '0;
    assign mem_req_wmask = req ? wmask : '0;
    always_comb begin
        state_nx = state;
        case (state)
            MEM_IDLE: state_nx = xfer && is_mem && !mis ? MEM_REQ : MEM_IDLE;
            MEM_REQ:  state_nx = mem_req_ready ? MEM_WAIT : MEM_REQ;
            MEM_WAIT: state_nx = mem_resp_valid ? MEM_OUT : MEM_WAIT;
            default:  state_nx = wb_ready ? MEM_IDLE : MEM_OUT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= MEM_IDLE;
            addr_q      <= '0;
            st_q        <= '0;
            f3_q        <= '0;
            rd_q        <= '0;
            wen_q       <= 1'b0;
            store_q     <= 1'b0;
            wb_valid    <= 1'b0;
            wb_rd_addr  <= '0;
            wb_rd_wen   <= 1'b0;
            wb_rd_data  <= '0;
            wb_misalign <= 1'b0;
        end else begin
            state <= state_nx;
            if (xfer) begin
                addr_q  <= in_alu_res;
                st_q    <= in_st_data;
                f3_q    <= in_funct3;
                rd_q    <= in_rd_addr;
                wen_q   <= in_rd_wen && in_rd_addr != 5'd0;
                store_q <= in_is_store;
            end
            if (xfer && (!is_mem || mis)) begin
                wb_valid    <= 1'b1;
                wb_rd_addr  <= in_rd_addr;
                wb_rd_wen   <= !is_mem && in_rd_wen && in_rd_addr != 5'd0;
                wb_rd_data  <= is_mem ? '0 : in_alu_res;
                wb_misalign <= is_mem;
            end else if (state == MEM_WAIT && mem_resp_valid) begin
                wb_valid    <= 1'b1;
                wb_rd_addr  <= rd_q;
                wb_rd_wen   <= !store_q && wen_q;
                wb_rd_data  <= store_q ? '0 : ldata;
                wb_misalign <= 1'b0;
            end else if (wb_ready) begin
                wb_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scenario tasks drive the memory stage; a scoreboard checks every write-back transfer
module tb_mem_stage;
    logic        clk, rst, in_valid, in_ready, in_is_load, in_is_store, in_rd_wen;
    logic [2:0]  in_funct3;
    logic [63:0] in_alu_res, in_st_data;
    logic [4:0]  in_rd_addr;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
    logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
    logic [7:0]  mem_req_wmask;
    logic        wb_valid, wb_ready, wb_rd_wen, wb_misalign;
    logic [4:0]  wb_rd_addr;
    logic [63:0] wb_rd_data;

    typedef struct {
        string       name;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] data;
        logic        mis;
        logic        dc;
    } exp_t;
    exp_t sb_q[$];
    exp_t e;
    int   checks = 0;
    int   errs = 0;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_alu_res(in_alu_res), .in_st_data(in_st_data),
        .in_rd_addr(in_rd_addr), .in_rd_wen(in_rd_wen),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd_addr(wb_rd_addr), .wb_rd_wen(wb_rd_wen),
        .wb_rd_data(wb_rd_data), .wb_misalign(wb_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errs++;
                $display("FAIL wb_unexpected: got transfer rd=%0d data=%h, required none", wb_rd_addr, wb_rd_data);
            end else begin
                e = sb_q.pop_front();
                if (wb_rd_addr !== e.rd || wb_rd_wen !== e.wen || wb_misalign !== e.mis || (!e.dc && wb_rd_data !== e.data)) begin
                    errs++;
                    $display("FAIL wb_%s: got rd=%0d wen=%b mis=%b data=%h, required rd=%0d wen=%b mis=%b data=%h",
                             e.name, wb_rd_addr, wb_rd_wen, wb_misalign, wb_rd_data, e.rd, e.wen, e.mis, e.data);
                end
            end
        end
    end

    task cyc;
        @(posedge clk);
        #1;
    endtask

    task drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
               input logic [63:0] a, input logic [63:0] sd, input logic [4:0] rd, input logic wen);
        in_valid = v; in_is_load = ld; in_is_store = st; in_funct3 = f3;
        in_alu_res = a; in_st_data = sd; in_rd_addr = rd; in_rd_wen = wen;
    endtask

    task test_reset;
        rst = 1'b1;
        cyc;
        cyc;
        checks++;
        if ({mem_req_valid, mem_req_wen, wb_valid, wb_rd_wen, wb_misalign} !== 5'b0) begin
            errs++;
            $display("FAIL reset_ctrl: got %b, required 00000", {mem_req_valid, mem_req_wen, wb_valid, wb_rd_wen, wb_misalign});
        end
        checks++;
        if (mem_req_addr !== 64'h0 || mem_req_wdata !== 64'h0 || mem_req_wmask !== 8'h0) begin
            errs++;
            $display("FAIL reset_req: got addr=%h wdata=%h wmask=%h, required all 0", mem_req_addr, mem_req_wdata, mem_req_wmask);
        end
        checks++;
        if (wb_rd_data !== 64'h0 || wb_rd_addr !== 5'd0) begin
            errs++;
            $display("FAIL reset_wb: got rd=%0d data=%h, required 0", wb_rd_addr, wb_rd_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        rst = 1'b0;
    endtask

    task test_back_to_back;
        logic [63:0] a;
        logic [4:0]  rd;
        logic        wen;
        wb_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errs++;
                $display("FAIL b2b_ready%0d: got %b, required 1", i, in_ready);
            end
            if (i > 0) begin
                checks++;
                if (wb_valid !== 1'b1) begin
                    errs++;
                    $display("FAIL b2b_latency%0d: got wb_valid=%b, required 1", i, wb_valid);
                end
            end
            a   = 64'h1234 + 64'(i) * 64'h1111;
            rd  = i == 4 ? 5'd0 : 5'(5 + i);
            wen = i != 3;
            drive(1'b1, 1'b0, 1'b0, 3'b000, a, 64'h0, rd, wen);
            sb_q.push_back('{"nonmem", rd, wen && rd != 5'd0, a, 1'b0, 1'b0});
            cyc;
        end
        drive(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 5'd0, 1'b0);
        cyc;
        checks++;
        if (wb_valid !== 1'b0 || sb_q.size() != 0) begin
            errs++;
            $display("FAIL b2b_drain: got wb_valid=%b pending=%0d, required 0 and 0", wb_valid, sb_q.size());
        end
    endtask

    task mem_txn(input string nm, input logic st, input logic [2:0] f3, input logic [63:0] a,
                 input logic [63:0] sd, input logic [4:0] rd, input logic [63:0] rdata,
                 input logic [7:0] emask, input logic [63:0] ewdata, input logic [63:0] edata,
                 input int rstall, input int wstall);
        sb_q.push_back('{nm, rd, !st && rd != 5'd0, st ? 64'h0 : edata, 1'b0, st});
        wb_ready = wstall == 0;
        drive(1'b1, !st, st, f3, a, sd, rd, 1'b1);
        cyc;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 5'd0, 1'b0);
        for (int k = 0; k <= rstall; k++) begin
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== {a[63:3], 3'b000} || mem_req_wen !== st || in_ready !== 1'b0) begin
                errs++;
                $display("FAIL %s_req%0d: got v=%b addr=%h wen=%b rdy=%b, required v=1 addr=%h wen=%b rdy=0",
                         nm, k, mem_req_valid, mem_req_addr, mem_req_wen, in_ready, {a[63:3], 3'b000}, st);
            end
            if (st) begin
                checks++;
                if (mem_req_wmask !== emask || mem_req_wdata !== ewdata) begin
                    errs++;
                    $display("FAIL %s_wdata%0d: got wmask=%h wdata=%h, required wmask=%h wdata=%h",
                             nm, k, mem_req_wmask, mem_req_wdata, emask, ewdata);
                end
            end
            mem_req_ready = k == rstall;
            cyc;
        end
        mem_req_ready = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0 || wb_valid !== 1'b0) begin
            errs++;
            $display("FAIL %s_wait: got req_v=%b wb_v=%b, required 0 0", nm, mem_req_valid, wb_valid);
        end
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdata;
        cyc;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 64'h0;
        checks++;
        if (wb_valid !== 1'b1) begin
            errs++;
            $display("FAIL %s_wb: got wb_valid=%b, required 1", nm, wb_valid);
        end
        for (int k = 0; k < wstall; k++) begin
            checks++;
            if (wb_valid !== 1'b1 || in_ready !== 1'b0) begin
                errs++;
                $display("FAIL %s_hold%0d: got wb_v=%b rdy=%b, required 1 0", nm, k, wb_valid, in_ready);
            end
            cyc;
        end
        wb_ready = 1'b1;
        cyc;
        checks++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1 || sb_q.size() != 0) begin
            errs++;
            $display("FAIL %s_done: got wb_v=%b rdy=%b pending=%0d, required 0 1 0", nm, wb_valid, in_ready, sb_q.size());
        end
    endtask

    task test_load;
        mem_txn("lw", 1'b0, 3'b010, 64'h80000004, 64'h0, 5'd10, 64'h80000000_00000000, 8'h0, 64'h0, 64'hFFFFFFFF_80000000, 0, 0);
        mem_txn("lwu", 1'b0, 3'b110, 64'h80000004, 64'h0, 5'd11, 64'h80000000_00000000, 8'h0, 64'h0, 64'h00000000_80000000, 0, 0);
        mem_txn("lb", 1'b0, 3'b000, 64'h80000005, 64'h0, 5'd12, 64'h00008500_00000000, 8'h0, 64'h0, 64'hFFFFFFFF_FFFFFF85, 0, 0);
        mem_txn("lhu", 1'b0, 3'b101, 64'h80000006, 64'h0, 5'd13, 64'hBEEF0000_00000000, 8'h0, 64'h0, 64'h00000000_0000BEEF, 0, 0);
        mem_txn("ld111", 1'b0, 3'b111, 64'h80000018, 64'h0, 5'd14, 64'hFEDCBA98_76543210, 8'h0, 64'h0, 64'hFEDCBA98_76543210, 0, 0);
        mem_txn("ld_x0", 1'b0, 3'b011, 64'h80000020, 64'h0, 5'd0, 64'h01234567_89ABCDEF, 8'h0, 64'h0, 64'h01234567_89ABCDEF, 0, 0);
    endtask

    task test_store;
        mem_txn("sb", 1'b1, 3'b000, 64'h80000003, 64'h0000_0000_0000_00AB, 5'd7, 64'h0, 8'h08, 64'h00000000_AB000000, 64'h0, 0, 0);
        mem_txn("sh", 1'b1, 3'b001, 64'h80000006, 64'h0000_0000_0000_1234, 5'd8, 64'h0, 8'hC0, 64'h12340000_00000000, 64'h0, 0, 0);
    endtask

    task test_backpressure;
        mem_txn("bp_sd", 1'b1, 3'b011, 64'h80000010, 64'hDEADBEEF_CAFEF00D, 5'd9, 64'h0, 8'hFF, 64'hDEADBEEF_CAFEF00D, 64'h0, 3, 2);
        mem_txn("bp_lh", 1'b0, 3'b001, 64'h80000002, 64'h0, 5'd15, 64'h00000000_8001_0000, 8'h0, 64'h0, 64'hFFFFFFFF_FFFF8001, 3, 2);
    endtask

    task test_misalign;
        logic [2:0]  f3;
        logic [63:0] a;
        logic        st;
        wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            f3 = i == 0 ? 3'b011 : i == 1 ? 3'b001 : 3'b010;
            a  = i == 0 ? 64'h80000004 : i == 1 ? 64'h80000001 : 64'h80000002;
            st = i == 2;
            sb_q.push_back('{"misalign", 5'(20 + i), 1'b0, 64'h0, 1'b1, 1'b1});
            drive(1'b1, !st, st, f3, a, 64'h55, 5'(20 + i), 1'b1);
            cyc;
            drive(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 5'd0, 1'b0);
            checks++;
            if (mem_req_valid !== 1'b0 || wb_valid !== 1'b1 || in_ready !== 1'b1) begin
                errs++;
                $display("FAIL misalign%0d_out: got req_v=%b wb_v=%b rdy=%b, required 0 1 1", i, mem_req_valid, wb_valid, in_ready);
            end
            cyc;
            checks++;
            if (mem_req_valid !== 1'b0 || wb_valid !== 1'b0) begin
                errs++;
                $display("FAIL misalign%0d_after: got req_v=%b wb_v=%b, required 0 0", i, mem_req_valid, wb_valid);
            end
        end
    endtask

    task test_reset_mid;
        wb_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 64'h80000004, 64'h0, 5'd3, 1'b1);
        cyc;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 5'd0, 1'b0);
        rst = 1'b1;
        cyc;
        rst = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL rst_req: got req_v=%b rdy=%b, required 0 1", mem_req_valid, in_ready);
        end
        drive(1'b1, 1'b1, 1'b0, 3'b010, 64'h80000004, 64'h0, 5'd3, 1'b1);
        cyc;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 5'd0, 1'b0);
        mem_req_ready = 1'b1;
        cyc;
        mem_req_ready = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b0) begin
            errs++;
            $display("FAIL rst_inwait: got req_v=%b wb_v=%b rdy=%b, required 0 0 0", mem_req_valid, wb_valid, in_ready);
        end
        rst = 1'b1;
        cyc;
        rst = 1'b0;
        checks++;
        if ({mem_req_valid, mem_req_wen, wb_valid, wb_rd_wen, wb_misalign} !== 5'b0 || mem_req_addr !== 64'h0 ||
            mem_req_wmask !== 8'h0 || wb_rd_data !== 64'h0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL rst_wait: got ctrl=%b addr=%h wmask=%h data=%h rdy=%b, required 0 0 0 0 1",
                     {mem_req_valid, mem_req_wen, wb_valid, wb_rd_wen, wb_misalign}, mem_req_addr, mem_req_wmask, wb_rd_data, in_ready);
        end
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'h80000000_00000000;
        cyc;
        mem_resp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (wb_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
                errs++;
                $display("FAIL rst_late_resp%0d: got wb_v=%b req_v=%b, required 0 0", k, wb_valid, mem_req_valid);
            end
            cyc;
        end
        drive(1'b1, 1'b0, 1'b0, 3'b000, 64'h77, 64'h0, 5'd4, 1'b1);
        sb_q.push_back('{"post_rst", 5'd4, 1'b1, 64'h77, 1'b0, 1'b0});
        cyc;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 5'd0, 1'b0);
        checks++;
        if (wb_valid !== 1'b1) begin
            errs++;
            $display("FAIL rst_recover: got wb_valid=%b, required 1", wb_valid);
        end
        cyc;
    endtask

    initial begin
        rst = 1'b1;
        wb_ready = 1'b0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 64'h0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 5'd0, 1'b0);
        test_reset;
        test_back_to_back;
        test_load;
        test_store;
        test_misalign;
        test_backpressure;
        test_reset_mid;
        cyc;
        checks++;
        if (sb_q.size() != 0) begin
            errs++;
            $display("FAIL scoreboard_empty: got %0d pending, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule
